// File: rtl/nds_rst_seq.sv
// ---------------------------------------------------------------------------
// nds_rst_seq
//
// Multi-channel reset synchroniser and sequencer for cluster reset domains
// that share one clock. The asynchronous active-low input reset has its
// deassertion synchronised, then NumChannels output resets are released in
// order (channel 0 first) with GapCycles clocks between releases. Once the
// power-on sequence is complete, each channel can be warm-reset on its own
// by software, with a one-cycle acknowledge when the hold finishes. A test
// mode routes i_rst_n straight to every output for scan.
//
// Optional build macro:
//   NDS_RST_SEQ_STATUS_EN - adds o_state (IDLE=0, SEQ=1, RUN=2) and
//                           o_warm_cnt (saturating count of accepted
//                           warm-reset requests across all channels).
//
// Ports:
//   i_clk         in   1            block clock
//   i_rst_n       in   1            async active-low reset, deassertion synchronised
//   i_test_mode   in   1            scan bypass: o_rst_n follows i_rst_n
//   i_sw_rst_req  in   NumChannels  per-channel warm-reset request (level)
//   o_rst_n       out  NumChannels  sequenced active-low resets
//   o_sw_rst_ack  out  NumChannels  one-cycle pulse when a warm reset completes
//   o_seq_done    out  1            high once the power-on sequence is done
//   o_state       out  2            FSM state (NDS_RST_SEQ_STATUS_EN only)
//   o_warm_cnt    out  8            accepted warm resets, saturating (NDS_RST_SEQ_STATUS_EN only)
// ---------------------------------------------------------------------------
module nds_rst_seq #(
    parameter int NumChannels = 4,
    parameter int SyncStages  = 2,
    parameter int GapCycles   = 4,
    parameter int HoldCycles  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_test_mode,
    input  logic [NumChannels-1:0] i_sw_rst_req,
    output logic [NumChannels-1:0] o_rst_n,
    output logic [NumChannels-1:0] o_sw_rst_ack,
    output logic                   o_seq_done
`ifdef NDS_RST_SEQ_STATUS_EN
    ,
    output logic [1:0]             o_state,
    output logic [7:0]             o_warm_cnt
`endif
);

    localparam int GW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam int HW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam int IW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    localparam logic [GW-1:0] GAP_LAST  = GW'(GapCycles - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HoldCycles - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NumChannels - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEQ  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [SyncStages-1:0]  r_sync;
    logic                   w_rst_sync;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [GW-1:0]          r_gap_cnt;
    logic [GW-1:0]          w_gap_nxt;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          w_idx_nxt;
    logic [NumChannels-1:0] r_rel;
    logic [NumChannels-1:0] w_rel_nxt;

    logic [NumChannels-1:0] r_hold;
    logic [NumChannels-1:0] w_hold_nxt;
    logic [HW-1:0]          r_hold_cnt [NumChannels];
    logic [NumChannels-1:0] w_accept;
    logic [NumChannels-1:0] w_hold_end;

    logic [NumChannels-1:0] r_rst_out;
    logic [NumChannels-1:0] r_ack;
    logic                   r_done;

    // Deassertion synchroniser: shifts in 1 after i_rst_n releases, the
    // last stage is the synchronised reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], 1'b1};
        end
    end

    assign w_rst_sync = r_sync[SyncStages-1];

    // Sequencer next state. IDLE leaves on the edge that sets the last
    // synchroniser stage (its D input is already 1), so the first gap is
    // counted from the same edge on which the synchronised release appears.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_idx_nxt   = r_idx;
        w_rel_nxt   = r_rel;
        case (r_state)
            S_IDLE: begin
                if (r_sync[SyncStages-2]) begin
                    w_state_nxt = S_SEQ;
                    w_gap_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_SEQ: begin
                if (w_rst_sync) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_nxt = '0;
                        for (int k = 0; k < NumChannels; k++) begin
                            if (r_idx == IW'(k)) begin
                                w_rel_nxt[k] = 1'b1;
                            end
                        end
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Warm-reset control. A request is only taken in RUN by an idle channel;
    // requests arriving mid-hold or before RUN simply fall on the floor.
    always_comb begin
        w_accept   = '0;
        w_hold_end = '0;
        w_hold_nxt = '0;
        for (int k = 0; k < NumChannels; k++) begin
            w_accept[k]   = (r_state == S_RUN) && !r_hold[k] && i_sw_rst_req[k];
            w_hold_end[k] = r_hold[k] && (r_hold_cnt[k] == HOLD_LAST);
            w_hold_nxt[k] = w_accept[k] || (r_hold[k] && !w_hold_end[k]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_rel     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_rel     <= w_rel_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
            for (int k = 0; k < NumChannels; k++) begin
                r_hold_cnt[k] <= '0;
            end
        end else begin
            r_hold <= w_hold_nxt;
            for (int k = 0; k < NumChannels; k++) begin
                if (w_accept[k] || w_hold_end[k]) begin
                    r_hold_cnt[k] <= '0;
                end else if (r_hold[k]) begin
                    r_hold_cnt[k] <= r_hold_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Outputs come straight from flops fed with the next-state values, so a
    // release or warm-reset entry shows on the same edge that decides it and
    // no combinational path exists from i_sw_rst_req to o_rst_n.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_out <= '0;
            r_ack     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_rst_out <= w_rel_nxt & ~w_hold_nxt;
            r_ack     <= w_hold_end;
            r_done    <= (w_state_nxt == S_RUN);
        end
    end

    // Scan bypass. This select is the spot for the glitch-free tech mux cell;
    // i_test_mode is static during scan so the select never toggles live.
    assign o_rst_n      = i_test_mode ? {NumChannels{i_rst_n}} : r_rst_out;
    assign o_sw_rst_ack = r_ack & {NumChannels{~i_test_mode}};
    assign o_seq_done   = r_done & ~i_test_mode;

`ifdef NDS_RST_SEQ_STATUS_EN
    localparam int CW = $clog2(NumChannels + 1);

    logic [7:0]    r_warm_cnt;
    logic [CW-1:0] w_accept_cnt;
    logic [8:0]    w_warm_sum;

    // Several channels can be accepted on one edge, so add the population
    // count of accepts and clamp at 255.
    always_comb begin
        w_accept_cnt = '0;
        for (int k = 0; k < NumChannels; k++) begin
            w_accept_cnt = w_accept_cnt + CW'(w_accept[k]);
        end
        w_warm_sum = {1'b0, r_warm_cnt} + 9'(w_accept_cnt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_warm_cnt <= '0;
        end else if (w_warm_sum > 9'd255) begin
            r_warm_cnt <= 8'd255;
        end else begin
            r_warm_cnt <= w_warm_sum[7:0];
        end
    end

    assign o_state    = r_state;
    assign o_warm_cnt = r_warm_cnt;
`endif

endmodule

// File: tb/tb_nds_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_nds_rst_seq
//
// Directed self-checking bench for nds_rst_seq with default parameters
// (NumChannels=4, SyncStages=2, GapCycles=4, HoldCycles=8). Inputs are driven
// and outputs sampled on the falling clock edge; "edge e" counts rising
// edges after the falling edge on which i_rst_n was released.
// ---------------------------------------------------------------------------
module tb_nds_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       test_mode;
    logic [3:0] sw_rst_req;
    logic [3:0] rst_out_n;
    logic [3:0] sw_rst_ack;
    logic       seq_done;
`ifdef NDS_RST_SEQ_STATUS_EN
    logic [1:0] state;
    logic [7:0] warm_cnt;
`endif

    int errors;
    int checks;

    // Release edges of channels 0..3 counted from the i_rst_n deassertion.
    int rise_edge [4] = '{6, 10, 14, 18};

    nds_rst_seq #(
        .NumChannels(4),
        .SyncStages (2),
        .GapCycles  (4),
        .HoldCycles (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_test_mode (test_mode),
        .i_sw_rst_req(sw_rst_req),
        .o_rst_n     (rst_out_n),
        .o_sw_rst_ack(sw_rst_ack),
        .o_seq_done  (seq_done)
`ifdef NDS_RST_SEQ_STATUS_EN
        ,
        .o_state     (state),
        .o_warm_cnt  (warm_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_power_on();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (rst_out_n !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_rst_n: got %b expected %b", rst_out_n, 4'b0000);
        end
        checks++;
        if (sw_rst_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b expected %b", sw_rst_ack, 4'b0000);
        end
        checks++;
        if (seq_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done: got %b expected 0", seq_done);
        end
    endtask

    task automatic test_power_on();
        logic [3:0] exp_rst;
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            for (int k = 0; k < 4; k++) exp_rst[k] = (e >= rise_edge[k]);
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL power_on_rst_n edge %0d: got %b expected %b", e, rst_out_n, exp_rst);
            end
            checks++;
            if (seq_done !== (e >= 18)) begin
                errors++;
                $display("[TB] FAIL power_on_done edge %0d: got %b expected %b", e, seq_done, (e >= 18));
            end
`ifdef NDS_RST_SEQ_STATUS_EN
            checks++;
            if (state !== ((e < 2) ? 2'd0 : ((e < 18) ? 2'd1 : 2'd2))) begin
                errors++;
                $display("[TB] FAIL power_on_state edge %0d: got %0d", e, state);
            end
`endif
        end
    endtask

    task automatic test_warm_reset();
        logic [3:0] exp_rst;
        logic [3:0] exp_ack;
        sw_rst_req = 4'b0100;
        step();
        sw_rst_req = 4'b0000;
        checks++;
        if (rst_out_n !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL warm_entry: got %b expected %b", rst_out_n, 4'b1011);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            exp_rst = (j >= 8) ? 4'b1111 : 4'b1011;
            exp_ack = (j == 8) ? 4'b0100 : 4'b0000;
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL warm_rst_n step %0d: got %b expected %b", j, rst_out_n, exp_rst);
            end
            checks++;
            if (sw_rst_ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL warm_ack step %0d: got %b expected %b", j, sw_rst_ack, exp_ack);
            end
        end
    endtask

    task automatic test_reject_hold();
        logic [3:0] exp_rst;
        logic [3:0] exp_ack;
        sw_rst_req = 4'b0010;
        step();
        for (int j = 1; j <= 12; j++) begin
            sw_rst_req = (j == 3) ? 4'b0010 : 4'b0000;
            step();
            exp_rst = (j >= 8) ? 4'b1111 : 4'b1101;
            exp_ack = (j == 8) ? 4'b0010 : 4'b0000;
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL reject_hold_rst_n step %0d: got %b expected %b", j, rst_out_n, exp_rst);
            end
            checks++;
            if (sw_rst_ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL reject_hold_ack step %0d: got %b expected %b", j, sw_rst_ack, exp_ack);
            end
        end
        sw_rst_req = 4'b0000;
    endtask

    // Channel 0 request held high across its release restarts at once;
    // channel 3 pulsed on the same edge runs its own hold alongside.
    task automatic test_back_to_back();
        logic [3:0] exp_rst;
        logic [3:0] exp_ack;
        sw_rst_req = 4'b1001;
        step();
        for (int j = 1; j <= 18; j++) begin
            sw_rst_req = (j <= 9) ? 4'b0001 : 4'b0000;
            step();
            exp_rst = 4'b0110;
            exp_rst[0] = (j == 8) || (j >= 17);
            exp_rst[3] = (j >= 8);
            exp_ack = 4'b0000;
            exp_ack[0] = (j == 8) || (j == 17);
            exp_ack[3] = (j == 8);
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL back_to_back_rst_n step %0d: got %b expected %b", j, rst_out_n, exp_rst);
            end
            checks++;
            if (sw_rst_ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL back_to_back_ack step %0d: got %b expected %b", j, sw_rst_ack, exp_ack);
            end
        end
        sw_rst_req = 4'b0000;
    endtask

    task automatic test_reject_seq();
        logic [3:0] exp_rst;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            sw_rst_req = (e >= 7 && e <= 9) ? 4'b0010 : 4'b0000;
            step();
            for (int k = 0; k < 4; k++) exp_rst[k] = (e >= rise_edge[k]);
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL reject_seq_rst_n edge %0d: got %b expected %b", e, rst_out_n, exp_rst);
            end
            checks++;
            if (sw_rst_ack !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reject_seq_ack edge %0d: got %b expected %b", e, sw_rst_ack, 4'b0000);
            end
        end
        sw_rst_req = 4'b0000;
    endtask

    task automatic test_async_mid();
        logic [3:0] exp_rst;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (12) step();
        checks++;
        if (rst_out_n !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL async_pre: got %b expected %b", rst_out_n, 4'b0011);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rst_out_n !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_assert_rst_n: got %b expected %b", rst_out_n, 4'b0000);
        end
        checks++;
        if (seq_done !== 1'b0 || sw_rst_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_assert_flags: got done=%b ack=%b expected 0 and 0000", seq_done, sw_rst_ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            for (int k = 0; k < 4; k++) exp_rst[k] = (e >= rise_edge[k]);
            checks++;
            if (rst_out_n !== exp_rst) begin
                errors++;
                $display("[TB] FAIL async_rerun_rst_n edge %0d: got %b expected %b", e, rst_out_n, exp_rst);
            end
            checks++;
            if (seq_done !== (e >= 18)) begin
                errors++;
                $display("[TB] FAIL async_rerun_done edge %0d: got %b expected %b", e, seq_done, (e >= 18));
            end
        end
    endtask

    task automatic test_test_mode();
        test_mode = 1'b1;
        #1;
        checks++;
        if (rst_out_n !== 4'b1111 || seq_done !== 1'b0 || sw_rst_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL test_mode_entry: got rst=%b done=%b ack=%b expected 1111 0 0000", rst_out_n, seq_done, sw_rst_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rst_out_n !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL test_mode_low: got %b expected %b", rst_out_n, 4'b0000);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rst_out_n !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL test_mode_high: got %b expected %b", rst_out_n, 4'b1111);
        end
        @(negedge clk);
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (rst_out_n !== 4'b1111 || seq_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL test_mode_run edge %0d: got rst=%b done=%b expected 1111 0", e, rst_out_n, seq_done);
            end
        end
        test_mode = 1'b0;
        #1;
        checks++;
        if (rst_out_n !== 4'b1111 || seq_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL test_mode_exit: got rst=%b done=%b expected 1111 1", rst_out_n, seq_done);
        end
        @(negedge clk);
    endtask

`ifdef NDS_RST_SEQ_STATUS_EN
    task automatic test_status();
        do_power_on();
        checks++;
        if (warm_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL status_cnt_reset: got %0d expected 0", warm_cnt);
        end
        for (int p = 0; p < 3; p++) begin
            sw_rst_req = 4'b0001;
            step();
            sw_rst_req = 4'b0000;
            repeat (10) step();
        end
        checks++;
        if (warm_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL status_cnt_three: got %0d expected 3", warm_cnt);
        end
        sw_rst_req = 4'b1111;
        repeat (700) step();
        sw_rst_req = 4'b0000;
        repeat (10) step();
        checks++;
        if (warm_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL status_cnt_sat: got %0d expected 255", warm_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b1;
        test_mode  = 1'b0;
        sw_rst_req = 4'b0000;
        #2 rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_power_on();
        test_warm_reset();
        test_reject_hold();
        test_back_to_back();
        test_reject_seq();
        test_async_mid();
        test_test_mode();
`ifdef NDS_RST_SEQ_STATUS_EN
        test_status();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
